// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous SRAM controller.
//   DefaultAddrW / DefaultDataW : geometry of the board's 512K x 8 part
//   sram_state_e                : controller FSM state encoding
//   max3()                      : sizes the shared wait counter
package sram_pkg;

  localparam int unsigned DefaultAddrW = 19;
  localparam int unsigned DefaultDataW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StTurn,
    StWrSetup,
    StWrPulse,
    StWrHold
  } sram_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_io_pad.sv
// Bidirectional data pad for the SRAM bus. Kept separate so a vendor IOB
// primitive can replace it without touching the controller.
//   clk, rst_n  : clock, asynchronous active-low reset (reset releases the bus)
//   oe_next     : next-state of the output enable flop
//   dout_load   : load dout_next into the output data flop
//   dout_next   : write data to present on the bus
//   din         : bus value as seen at the pad (captured by the controller)
//   io          : the SRAM data pins
module sram_io_pad
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              oe_next,
  input  logic              dout_load,
  input  logic [DATA_W-1:0] dout_next,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] io
);

  logic              oe_q;
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      oe_q <= oe_next;
      if (dout_load) dout_q <= dout_next;
    end
  end

  assign io  = oe_q ? dout_q : {DATA_W{1'bz}};
  assign din = io;

endmodule

// File: rtl/sram_async_ctrl.sv
// Single-beat valid/ready front end for a 10 ns asynchronous SRAM.
//   clk, rst_n           : system clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (accept when both high at a rising edge)
//   req_we               : 1 = write, 0 = read
//   req_addr, req_wdata  : word address and write data
//   rsp_valid            : one-cycle pulse when rsp_rdata holds fresh read data
//   rsp_rdata            : last read data, held until the next read completes
//   sram_a, sram_io      : SRAM address and bidirectional data
//   sram_ce_n/oe_n/we_n  : active-low SRAM strobes
// Every SRAM-side signal comes straight from a flop.
module sram_async_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned WE_PULSE = 1,
  parameter int unsigned TURN     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_a,
  inout  wire  [DATA_W-1:0] sram_io,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int unsigned CntMax = max3(RD_WAIT, WE_PULSE, TURN);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  sram_state_e       state_q;
  logic [CntW-1:0]   cnt_q;
  logic              accept;
  logic              io_oe_next;
  logic              io_load;
  logic [DATA_W-1:0] io_din;

  // req_ready is high in IDLE and in WR_HOLD, so a write can be followed
  // without a dead cycle; reads always return through TURN to IDLE.
  assign accept  = req_valid & req_ready;
  assign io_load = accept & req_we;

  // Bus is driven from the cycle after a write is accepted through WR_HOLD.
  always_comb begin
    io_oe_next = 1'b0;
    if (accept) begin
      io_oe_next = req_we;
    end else if (state_q == StWrSetup || state_q == StWrPulse) begin
      io_oe_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      sram_a    <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        sram_a    <= req_addr;
        sram_ce_n <= 1'b0;
        sram_we_n <= 1'b1;
        req_ready <= 1'b0;
        if (req_we) begin
          sram_oe_n <= 1'b1;
          state_q   <= StWrSetup;
        end else begin
          sram_oe_n <= 1'b0;
          cnt_q     <= CntW'(RD_WAIT);
          state_q   <= StRd;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
          end
          StRd: begin
            if (cnt_q == CntW'(1)) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= io_din;
              sram_ce_n <= 1'b1;
              sram_oe_n <= 1'b1;
              cnt_q     <= CntW'(TURN);
              state_q   <= StTurn;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          StTurn: begin
            if (cnt_q == CntW'(1)) begin
              req_ready <= 1'b1;
              state_q   <= StIdle;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          StWrSetup: begin
            sram_we_n <= 1'b0;
            cnt_q     <= CntW'(WE_PULSE);
            state_q   <= StWrPulse;
          end
          StWrPulse: begin
            if (cnt_q == CntW'(1)) begin
              sram_we_n <= 1'b1;
              req_ready <= 1'b1;
              state_q   <= StWrHold;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          StWrHold: begin
            sram_ce_n <= 1'b1;
            state_q   <= StIdle;
          end
          default: begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            req_ready <= 1'b1;
            state_q   <= StIdle;
          end
        endcase
      end
    end
  end

  sram_io_pad #(
    .DATA_W(DATA_W)
  ) u_pad (
    .clk      (clk),
    .rst_n    (rst_n),
    .oe_next  (io_oe_next),
    .dout_load(io_load),
    .dout_next(req_wdata),
    .din      (io_din),
    .io       (sram_io)
  );

endmodule

// File: tb/tb_sram_async_ctrl.sv
module tb_sram_async_ctrl;

  localparam int unsigned AW  = 19;
  localparam int unsigned DW  = 8;
  localparam int unsigned RDW = 3;
  localparam int unsigned WEP = 2;
  localparam int unsigned TRN = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] sram_a;
  wire  [DW-1:0] sram_io;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;

  sram_async_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RD_WAIT (RDW),
    .WE_PULSE(WEP),
    .TURN    (TRN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .sram_a   (sram_a),
    .sram_io  (sram_io),
    .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM device model: drives on CE&OE&!WE, stores on WE rising.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign sram_io = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_a] : {DW{1'bz}};
  always @(posedge sram_we_n) if (rst_n && !sram_ce_n) mem[sram_a] <= sram_io;

  // Accept log: cycle number of every handshake.
  int cyc = 0;
  int acc_cyc[$];
  always @(posedge clk) begin
    cyc++;
    if (rst_n && req_valid && req_ready) acc_cyc.push_back(cyc);
  end

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] last_rd = '0;
  logic [DW-1:0] ref_mem [int unsigned];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Issue one request starting at a falling edge and check every following
  // cycle until the controller is ready again. k counts falling edges after
  // the accept edge (k=0 is the first).
  task automatic do_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [DW-1:0] exp, input bit hold);
    int waited;
    int last_k;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    waited    = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    last_k = we ? WEP + 1 : RDW + TRN;
    for (int k = 0; k <= last_k; k++) begin
      if (k > 0) @(negedge clk);
      check("req_ready", req_ready, k == last_k);
      check("addr", sram_a, addr);
      if (we) begin
        check("wr_we_n", sram_we_n, !(k >= 1 && k <= WEP));
        check("wr_ce_n", sram_ce_n, 0);
        check("wr_oe_n", sram_oe_n, 1);
        check("wr_data", sram_io, wdata);
        check("wr_rsp_valid", rsp_valid, 0);
        check("rdata_held", rsp_rdata, last_rd);
      end else begin
        check("rd_we_n", sram_we_n, 1);
        check("rd_ce_n", sram_ce_n, k >= RDW);
        check("rd_oe_n", sram_oe_n, k >= RDW);
        check("rsp_valid", rsp_valid, k == RDW);
        check("rsp_rdata", rsp_rdata, (k >= RDW) ? exp : last_rd);
      end
    end
    if (!we) last_rd = exp;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          tbl[9];
  logic [AW-1:0] pool[16];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int            n0;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;

    tbl[0] = '{1'b1, 19'h12345, 8'hA5, 8'h00};
    tbl[1] = '{1'b0, 19'h12345, 8'h00, 8'hA5};
    tbl[2] = '{1'b1, 19'h00000, 8'h00, 8'h00};
    tbl[3] = '{1'b1, 19'h7FFFF, 8'hFF, 8'h00};
    tbl[4] = '{1'b0, 19'h00000, 8'h00, 8'h00};
    tbl[5] = '{1'b0, 19'h7FFFF, 8'h00, 8'hFF};
    tbl[6] = '{1'b1, 19'h7FFFE, 8'h3C, 8'h00};
    tbl[7] = '{1'b0, 19'h7FFFF, 8'h00, 8'hFF};
    tbl[8] = '{1'b0, 19'h7FFFE, 8'h00, 8'h3C};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_sram_a", sram_a, 0);
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_we_n", sram_we_n, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 1'b0);
      if (tbl[i].we) ref_mem[tbl[i].addr] = tbl[i].wdata;
    end

    // Read then write with req_valid held high throughout.
    n0 = acc_cyc.size();
    do_op(1'b0, 19'h12345, 8'h00, 8'hA5, 1'b1);
    do_op(1'b1, 19'h00100, 8'h6E, 8'h00, 1'b0);
    ref_mem[19'h00100] = 8'h6E;
    check("b2b_rd_wr_accepts", acc_cyc.size() - n0, 2);
    if (acc_cyc.size() == n0 + 2) check("b2b_rd_wr_gap", acc_cyc[n0+1] - acc_cyc[n0], RDW + TRN + 1);

    // Write then read, back to back.
    n0 = acc_cyc.size();
    do_op(1'b1, 19'h00200, 8'h91, 8'h00, 1'b1);
    do_op(1'b0, 19'h00100, 8'h00, 8'h6E, 1'b0);
    ref_mem[19'h00200] = 8'h91;
    check("b2b_wr_rd_accepts", acc_cyc.size() - n0, 2);
    if (acc_cyc.size() == n0 + 2) check("b2b_wr_rd_gap", acc_cyc[n0+1] - acc_cyc[n0], WEP + 2);

    // Reset during the WE pulse.
    req_we    = 1'b1;
    req_addr  = 19'h00777;
    req_wdata = 8'h5A;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_we_low", sram_we_n, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we_n", sram_we_n, 1);
    check("mid_rst_ce_n", sram_ce_n, 1);
    check("mid_rst_oe_n", sram_oe_n, 1);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_rsp_rdata", rsp_rdata, 0);
    check("mid_rst_sram_a", sram_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_we_n", sram_we_n, 1);
    ref_mem.delete(19'h00777);
    last_rd = '0;

    // Random traffic against the reference array.
    for (int i = 0; i < 16; i++) pool[i] = AW'($urandom);
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0:       addr = '0;
        1:       addr = 19'h7FFFF;
        default: addr = pool[$urandom_range(0, 15)];
      endcase
      we    = ($urandom_range(0, 1) == 1) || !ref_mem.exists(addr);
      wdata = DW'($urandom);
      exp   = we ? 8'h00 : ref_mem[addr];
      do_op(we, addr, wdata, exp, 1'b0);
      if (we) ref_mem[addr] = wdata;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
